// File: rtl/sensor_input_conditioner_if.sv
// Bundle of raw switch inputs and conditioned outputs for the sensor input conditioner.
interface sensor_input_conditioner_if;
    logic [5:0] raw_sensors;
    logic [1:0] raw_buttons;
    logic [5:0] sensors_clean;
    logic [1:0] buttons_level;
    logic [1:0] button_press;
    logic       sensors_valid;
    logic       level_conflict;

    modport master (
        output raw_sensors,
        output raw_buttons,
        input  sensors_clean,
        input  buttons_level,
        input  button_press,
        input  sensors_valid,
        input  level_conflict
    );

    modport slave (
        input  raw_sensors,
        input  raw_buttons,
        output sensors_clean,
        output buttons_level,
        output button_press,
        output sensors_valid,
        output level_conflict
    );
endinterface

// File: rtl/sensor_input_conditioner.sv
// Synchronizes and debounces six sensor switches and two push buttons, generates press pulses,
// a startup-valid flag and a water-level consistency flag.
module sensor_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 16,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    sensor_input_conditioner_if.slave   io_sic
);
    localparam int         NCH        = 8;
    localparam logic [7:0] CNT_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [8:0] START_LAST = 9'(DEBOUNCE_CYCLES + 1);

    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] r_filt;
    logic [7:0]     r_cnt [NCH];
    logic [NCH-1:0] w_filt_next;
    logic [7:0]     w_cnt_next [NCH];
    logic [8:0]     r_start;
    logic           r_valid;
    logic           w_valid_next;
    logic [1:0]     r_press;
    logic           r_conflict;
    logic           w_conflict;

    // Buttons are folded to active-high before the synchronizer so reset 0 means "released".
    assign w_raw = {(BUTTON_ACTIVE_LOW ? ~io_sic.raw_buttons : io_sic.raw_buttons),
                    io_sic.raw_sensors};

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_filt_next[i] = r_filt[i];
            w_cnt_next[i]  = 8'd0;
            if (r_sync2[i] != r_filt[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_filt_next[i] = r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_valid_next = r_valid | (r_start == START_LAST);

    // Conflict looks at the filtered levels before this edge, giving the one-cycle lag.
    assign w_conflict = (r_filt[2] & ~r_filt[1]) |
                        (r_filt[1] & ~r_filt[0]) |
                        (r_filt[2] & ~r_filt[0]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_filt     <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= 8'd0;
            end
            r_start    <= 9'd0;
            r_valid    <= 1'b0;
            r_press    <= 2'b00;
            r_conflict <= 1'b0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_filt  <= w_filt_next;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            if (!r_valid) begin
                r_start <= r_start + 9'd1;
            end
            r_valid    <= w_valid_next;
            r_press    <= w_filt_next[7:6] & ~r_filt[7:6] & {2{w_valid_next}};
            r_conflict <= w_conflict & w_valid_next;
        end
    end

    assign io_sic.sensors_clean  = r_filt[5:0];
    assign io_sic.buttons_level  = r_filt[7:6];
    assign io_sic.button_press   = r_press;
    assign io_sic.sensors_valid  = r_valid;
    assign io_sic.level_conflict = r_conflict;
endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Bench for sensor_input_conditioner: default and DEBOUNCE_CYCLES=2 instances run side by side
// against a window-based reference model.
module tb_sensor_input_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] raw_s;
    logic [1:0] raw_b;
    int         checks   = 0;
    int         failures = 0;

    sensor_input_conditioner_if sic16();
    sensor_input_conditioner_if sic2();

    assign sic16.raw_sensors = raw_s;
    assign sic16.raw_buttons = raw_b;
    assign sic2.raw_sensors  = raw_s;
    assign sic2.raw_buttons  = raw_b;

    sensor_input_conditioner u_dut16 (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_sic (sic16.slave)
    );

    sensor_input_conditioner #(
        .DEBOUNCE_CYCLES   (2),
        .BUTTON_ACTIVE_LOW (1'b1)
    ) u_dut2 (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_sic (sic2.slave)
    );

    always #5 clk = ~clk;

    // Reference model: a filtered bit flips once the last N synchronized samples all disagree with it.
    int         n_cfg [2] = '{16, 2};
    logic [7:0] rawq  [$];
    logic [7:0] sampq [$];
    int         edges;
    logic [7:0] m_flt   [2];
    logic [1:0] m_press [2];
    logic       m_valid [2];
    logic       m_conf  [2];

    task automatic model_reset();
        rawq.delete();
        sampq.delete();
        edges = 0;
        for (int k = 0; k < 2; k++) begin
            m_flt[k]   = 8'h00;
            m_press[k] = 2'b00;
            m_valid[k] = 1'b0;
            m_conf[k]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [7:0] samp;
        logic [7:0] prev;
        bit         all_diff;
        rawq.push_back({~raw_b, raw_s});
        if (rawq.size() >= 3) samp = rawq[rawq.size()-3];
        else                  samp = 8'h00;
        sampq.push_back(samp);
        edges++;
        for (int k = 0; k < 2; k++) begin
            prev       = m_flt[k];
            m_valid[k] = (edges >= n_cfg[k] + 2);
            for (int ch = 0; ch < 8; ch++) begin
                if (sampq.size() >= n_cfg[k]) begin
                    all_diff = 1'b1;
                    for (int j = 1; j <= n_cfg[k]; j++)
                        if (sampq[sampq.size()-j][ch] == prev[ch]) all_diff = 1'b0;
                    if (all_diff) m_flt[k][ch] = ~prev[ch];
                end
            end
            m_press[k] = m_flt[k][7:6] & ~prev[7:6] & {2{m_valid[k]}};
            m_conf[k]  = m_valid[k] & ((prev[2] & ~prev[1]) | (prev[1] & ~prev[0]) | (prev[2] & ~prev[0]));
        end
        while (rawq.size() > 4) rawq.delete(0);
        while (sampq.size() > 40) sampq.delete(0);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("clean16", {2'b00, sic16.sensors_clean},   {2'b00, m_flt[0][5:0]});
        chk("level16", {6'd0, sic16.buttons_level},    {6'd0, m_flt[0][7:6]});
        chk("press16", {6'd0, sic16.button_press},     {6'd0, m_press[0]});
        chk("valid16", {7'd0, sic16.sensors_valid},    {7'd0, m_valid[0]});
        chk("conf16",  {7'd0, sic16.level_conflict},   {7'd0, m_conf[0]});
        chk("clean2",  {2'b00, sic2.sensors_clean},    {2'b00, m_flt[1][5:0]});
        chk("level2",  {6'd0, sic2.buttons_level},     {6'd0, m_flt[1][7:6]});
        chk("press2",  {6'd0, sic2.button_press},      {6'd0, m_press[1]});
        chk("valid2",  {7'd0, sic2.sensors_valid},     {7'd0, m_valid[1]});
        chk("conf2",   {7'd0, sic2.level_conflict},    {7'd0, m_conf[1]});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asserts reset between edges, checks the immediate clear, and releases it just after an edge.
    task automatic pulse_reset(input int hold_edges);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (hold_edges) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst = 1'b0;
    endtask

    initial begin
        int v16, v2, r16, r2, g, cnt, sel;
        raw_s = 6'h3F;
        raw_b = 2'b11;
        #2;
        pulse_reset(2);

        // Inputs held high through reset appear together with sensors_valid.
        v16 = 0; v2 = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (v16 == 0 && sic16.sensors_valid) v16 = i;
            if (v2 == 0 && sic2.sensors_valid) v2 = i;
        end
        chk("valid_lat16", 8'(v16), 8'd18);
        chk("valid_lat2",  8'(v2),  8'd4);

        raw_s = 6'h00;
        repeat (25) step();

        raw_s[0] = 1'b1;
        r16 = 0; r2 = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (r16 == 0 && sic16.sensors_clean[0]) r16 = i;
            if (r2 == 0 && sic2.sensors_clean[0]) r2 = i;
        end
        chk("rise_lat16", 8'(r16), 8'd18);
        chk("rise_lat2",  8'(r2),  8'd4);

        g = 0;
        raw_s[1] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (sic16.sensors_clean[1]) g = 1;
        end
        raw_s[1] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sic16.sensors_clean[1]) g = 1;
        end
        chk("glitch15_16", 8'(g), 8'd0);

        g = 0;
        raw_s[2] = 1'b1;
        step();
        raw_s[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sic2.sensors_clean[2]) g = 1;
        end
        chk("glitch1_2", 8'(g), 8'd0);

        cnt = 0;
        raw_b[1] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            cnt += int'(sic16.button_press[1]);
        end
        chk("press_once", 8'(cnt), 8'd1);
        cnt = 0;
        raw_b[1] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            cnt += int'(sic16.button_press[1]);
        end
        chk("release_nopulse", 8'(cnt), 8'd0);

        cnt = 0;
        for (int t = 0; t < 4; t++) begin
            raw_b[1] = ~raw_b[1];
            for (int i = 0; i < 3; i++) begin
                step();
                cnt += int'(sic16.button_press[1]);
            end
        end
        raw_b[1] = 1'b0;
        r16 = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            cnt += int'(sic16.button_press[1]);
            if (r16 == 0 && sic16.button_press[1]) r16 = i;
        end
        chk("bounce_lat", 8'(r16), 8'd18);
        chk("bounce_count", 8'(cnt), 8'd1);
        raw_b = 2'b11;
        repeat (25) step();

        raw_s = 6'b000100;
        repeat (25) step();
        chk("conflict_100", {7'd0, sic16.level_conflict}, 8'd1);
        raw_s = 6'b000011;
        repeat (25) step();
        chk("conflict_011", {7'd0, sic16.level_conflict}, 8'd0);

        raw_s = 6'h00;
        repeat (25) step();
        raw_s[4] = 1'b1;
        repeat (12) step();
        pulse_reset(1);
        r16 = 0; v16 = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (r16 == 0 && sic16.sensors_clean[4]) r16 = i;
            if (v16 == 0 && sic16.sensors_valid) v16 = i;
        end
        chk("rst_abort_lat", 8'(r16), 8'd18);
        chk("rst_valid_lat", 8'(v16), 8'd18);

        for (int seg = 0; seg < 80; seg++) begin
            sel = int'($urandom_range(0, 2));
            case (sel)
                0: begin
                    raw_s = 6'($urandom);
                    raw_b = 2'($urandom);
                end
                1: raw_s = raw_s ^ 6'(1 << $urandom_range(0, 5));
                default: raw_b = raw_b ^ 2'(1 << $urandom_range(0, 1));
            endcase
            if (seg == 40) pulse_reset(1);
            repeat ($urandom_range(1, 30)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sensor_input_conditioner.md
SENSOR_INPUT_CONDITIONER -- requirements
Module: sensor_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive synchronized samples that must differ from the filtered value before that value changes; legal range 2..255.
REQ-002 Parameter BUTTON_ACTIVE_LOW, default 1: when 1, raw_buttons are inverted before synchronization; when 0, they are used as-is.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 raw_sensors  input  6  unsynchronized switch levels; bit0 low_water_level, bit1 mid_water_level, bit2 high_water_level, bit3 earth_humidity, bit4 air_humidity, bit5 low_temperature.
REQ-006 raw_buttons  input  2  unsynchronized push buttons; bit0 pulse_2, bit1 pulse_3.
REQ-007 sensors_clean  output  6  debounced sensor levels, same bit order as raw_sensors.
REQ-008 buttons_level  output  2  debounced button levels, active-high (1 = pressed).
REQ-009 button_press  output  2  one-cycle pulse per debounced press, per bit.
REQ-010 sensors_valid  output  1  high once the startup settling window has elapsed.
REQ-011 level_conflict  output  1  registered water-level inconsistency flag derived from sensors_clean.

Function
REQ-012 The block shall have 8 independent channels: 6 sensors and 2 buttons; each channel shall use a 2-flop synchronizer, an 8-bit stability counter and one filtered-value register.
REQ-013 Per channel, when the synchronized sample equals the filtered value, the counter shall clear to 0.
REQ-014 Per channel, when the synchronized sample differs and the counter is below DEBOUNCE_CYCLES-1, the counter shall increment.
REQ-015 Per channel, when the synchronized sample differs and the counter equals DEBOUNCE_CYCLES-1, the filtered value shall take the sample and the counter shall clear, both on the same edge.
REQ-016 Latency: a raw change held stable shall appear on the output on exactly the (DEBOUNCE_CYCLES+2)th rising edge, counting from and including the first edge that samples the new value (18 edges at default).
REQ-017 A raw pulse that reverts before the counter reaches DEBOUNCE_CYCLES-1 shall leave the filtered value unchanged and return the counter to 0.
REQ-018 The counter shall never exceed DEBOUNCE_CYCLES-1 and shall never wrap.
REQ-019 button_press[i] shall be high for exactly the one cycle in which buttons_level[i] first reads 1 after reading 0; a release shall produce no pulse; a held button shall produce no further pulses.
REQ-020 Both buttons pressed together shall produce independent, possibly coincident pulses.
REQ-021 A startup counter shall count rising edges after reset deassertion; sensors_valid shall go high on the (DEBOUNCE_CYCLES+2)th edge and stay high until the next reset.
REQ-022 While sensors_valid is 0, button_press shall be forced to 0; filtering shall continue normally during that window.
REQ-023 level_conflict shall be registered with a one-cycle lag from sensors_clean, and shall be 1 when (bit2 & ~bit1) | (bit1 & ~bit0) | (bit2 & ~bit0).
REQ-024 level_conflict shall be forced to 0 while sensors_valid is 0.

Reset
REQ-025 While reset is high, all synchronizer flops, filtered values, counters, the startup counter, button_press, sensors_valid and level_conflict shall be 0; for buttons, 0 denotes the inactive level after polarity handling.
REQ-026 Reset asserted mid-count shall abort every pending transition; after deassertion, filtering shall restart from all-zero state.
REQ-027 Inputs held at 1 through reset shall reach sensors_clean exactly DEBOUNCE_CYCLES+2 edges after deassertion, on the same edge sensors_valid rises.

Verification
REQ-028 Default parameters; raw_sensors[0] goes 0->1 and is held -> sensors_clean[0] rises on edge 18; a 15-cycle glitch on raw_sensors[1] -> sensors_clean[1] stays 0.
REQ-029 BUTTON_ACTIVE_LOW=1; raw_buttons[1] driven low for 40 cycles after sensors_valid -> button_press[1] high for exactly 1 cycle; no pulse on release.
REQ-030 Bouncing button: 5 toggles at 3-cycle spacing, then stable low -> exactly one press pulse, 18 edges after the last toggle.
REQ-031 sensors_clean = 3'b100 on bits 2..0 after valid -> level_conflict = 1 one cycle later; 3'b011 -> level_conflict = 0.
REQ-032 Reset pulsed at count 10 of a pending change -> outputs 0 immediately; the change appears 18 edges after deassertion, together with sensors_valid.
REQ-033 DEBOUNCE_CYCLES=2 -> transition latency is 4 edges; a 1-cycle glitch is rejected.
